prom_fetch_ctl: RTL

//  Parametrised boot-PROM control and fetch sequencer for the microcode fetch path.

---
 rtl/prom_fetch_ctl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prom_fetch_ctl.sv
// prom_fetch_ctl
//   Boot-PROM control and fetch sequencer for the microcode fetch path.
//   A fetch request whose PC falls in the low boot window, inside the PROM,
//   while the PROM is enabled, runs a registered read of a synchronous PROM
//   with ROM_LAT cycles of latency. The word is returned over a valid/ready
//   handshake. Any other request produces a one-cycle miss pulse, and the
//   I-RAM path serves that fetch instead.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   pc, fetch_req                fetch PC and level request (taken when idle)
//   idebug, iwrited              inhibit the PROM (debug path / I-RAM write)
//   disable_set, disable_clr     sticky software PROM disable (set wins)
//   rom_data                     PROM read data
//   fetch_ready                  consumer accepts fetch_data
//   bottom_win, promenable       combinational window / enable decode
//   promdisabled                 sticky disable register
//   promce, promaddr             registered PROM strobe and address
//   fetch_valid, fetch_data      returned PROM word
//   fetch_miss                   one-cycle pulse for a request the PROM did not serve
//   fetch_busy                   a PROM fetch is in flight
//   fetch_cnt                    completed PROM fetches, saturating
//
// state | meaning
// IDLE  | waiting for a request; the hit/miss decision is made here
// READ  | PROM strobed, latency counter running down to capture
// HOLD  | word presented, waiting for fetch_ready
module prom_fetch_ctl #(
  parameter int PC_W      = 14,
  parameter int WINDOW_AW = 10,
  parameter int PROM_AW   = 9,
  parameter int DW        = 49,
  parameter int ROM_LAT   = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PC_W-1:0]    pc,
  input  logic               fetch_req,
  input  logic               idebug,
  input  logic               iwrited,
  input  logic               disable_set,
  input  logic               disable_clr,
  input  logic [DW-1:0]      rom_data,
  input  logic               fetch_ready,
  output logic               bottom_win,
  output logic               promenable,
  output logic               promdisabled,
  output logic               promce,
  output logic [PROM_AW-1:0] promaddr,
  output logic               fetch_valid,
  output logic [DW-1:0]      fetch_data,
  output logic               fetch_miss,
  output logic               fetch_busy,
  output logic [CNT_W-1:0]   fetch_cnt
);

  localparam int LAT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_HOLD} state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               promce_q, promce_d;
  logic [PROM_AW-1:0] promaddr_q, promaddr_d;
  logic               valid_q, valid_d;
  logic [DW-1:0]      data_q, data_d;
  logic               miss_q, miss_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dis_q, dis_d;
  logic               in_prom_sub;
  logic               in_prom;

  assign bottom_win = (pc[PC_W-1:WINDOW_AW] == '0);
  assign promenable = bottom_win & ~idebug & ~dis_q & ~iwrited;

  // When the PROM fills the whole window there are no bits between the two
  // address widths to check.
  generate
    if (WINDOW_AW > PROM_AW) begin : g_sub
      assign in_prom_sub = (pc[WINDOW_AW-1:PROM_AW] == '0);
    end else begin : g_full
      assign in_prom_sub = 1'b1;
    end
  endgenerate

  assign in_prom = promenable & in_prom_sub;

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    promce_d   = 1'b0;
    promaddr_d = promaddr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    miss_d     = 1'b0;
    cnt_d      = cnt_q;
    dis_d      = dis_q;

    if (disable_set)      dis_d = 1'b1;
    else if (disable_clr) dis_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          if (in_prom) begin
            promce_d   = 1'b1;
            promaddr_d = pc[PROM_AW-1:0];
            lat_d      = LAT_W'(ROM_LAT);
            state_d    = ST_READ;
          end else begin
            miss_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        // Capture on the edge after the counter reaches zero, so valid rises
        // ROM_LAT+1 edges after the accepting edge.
        if (lat_q == '0) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_HOLD: begin
        if (fetch_ready) begin
          valid_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      promce_q   <= 1'b0;
      promaddr_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      miss_q     <= 1'b0;
      cnt_q      <= '0;
      dis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      promce_q   <= promce_d;
      promaddr_q <= promaddr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      miss_q     <= miss_d;
      cnt_q      <= cnt_d;
      dis_q      <= dis_d;
    end
  end

  assign promdisabled = dis_q;
  assign promce       = promce_q;
  assign promaddr     = promaddr_q;
  assign fetch_valid  = valid_q;
  assign fetch_data   = data_q;
  assign fetch_miss   = miss_q;
  assign fetch_busy   = (state_q != ST_IDLE);
  assign fetch_cnt    = cnt_q;

endmodule
